alarm_beeper: RTL and testbench
===============================

// Module: alarm_beeper
// PURPOSE
//   Upstream driver for the noise tone stage. Turns a level alarm request into a
//   cadenced beep pattern (BEEPS short beeps, then a pause, repeated) on buzzer_on.
//   A debounced silence button mutes the alarm through no_buzz.
//   Outputs connect directly to noise.buzzer_on / noise.NoBuzz.
// PARAMETERS
//   CLK_HZ      100_000_000  system clock frequency
//   TICK_HZ     1000         timebase tick rate (1 ms)
//   ON_MS       200          beep-on duration, ticks (>=1)
//   OFF_MS      100          gap between beeps in a burst, ticks (>=1)
//   BEEPS       3            beeps per burst (>=1)
//   PAUSE_MS    1000         pause after each burst, ticks (>=1)
//   MAX_BURSTS  30           bursts before auto-stop; 0 = ring until silenced/dropped
//   DEBOUNCE_MS 20           silence button stable time, ticks (>=1)
//   SNOOZE_MS   60000        snooze length, ticks (SNOOZE_EN only)
// PORTS
//   clk          in   1  100 MHz system clock
//   rst_n        in   1  async active-low reset
//   alarm_req    in   1  synchronous level; high while alarm condition holds
//   silence_btn  in   1  raw asynchronous pushbutton, active high
//   buzzer_on    out  1  registered; high during beep-on phases
//   no_buzz      out  1  registered; mute override, high in SILENCED/DONE/SNOOZE
//   alarm_active out  1  registered; high in any state except IDLE
//   burst_cnt    out  8  completed bursts in the current alarm, saturates at 255
// BEHAVIOUR
// - Reset (async assert, sync release): state IDLE; all outputs 0; counters 0.
// - Prescaler: free-running, tick = 1-cycle pulse every CLK_HZ/TICK_HZ cycles.
//   It is cleared when an alarm starts, so the first phase is exact.
// - Phase timer: cleared on every state entry. A phase ends on the tick where
//   timer == duration-1. The state changes on that same clock edge.
// - States and transitions:
//   IDLE: on alarm_req rising edge -> BEEP_ON, beep_idx=0, burst_cnt=0.
//     buzzer_on goes high the next cycle (1-cycle latency).
//   BEEP_ON: buzzer_on=1. At ON_MS end: beep_idx==BEEPS-1 -> PAUSE, else -> BEEP_OFF.
//   BEEP_OFF: buzzer_on=0. At OFF_MS end -> BEEP_ON, beep_idx+1.
//   PAUSE: buzzer_on=0. At PAUSE_MS end burst_cnt+1. Then:
//     MAX_BURSTS!=0 and count reached -> DONE; else -> BEEP_ON, beep_idx=0.
//   SILENCED / DONE: buzzer_on=0, no_buzz=1. alarm_req low -> IDLE.
// - Exit priority while ringing (BEEP_ON/BEEP_OFF/PAUSE, highest first):
//   1. alarm_req low -> IDLE next cycle, all outputs 0.
//   2. Accepted press -> SILENCED.
//   3. Normal phase transition.
// - Silence button path:
//   - Input: 2-FF synchronizer, then debounce. The level is accepted only after
//     DEBOUNCE_MS consecutive stable ticks.
//   - Press = rising edge of the debounced level. It acts once per press;
//     holding the button has no further effect.
//   - In IDLE a press is ignored.
//   - A press on the same cycle as an alarm_req rising edge: alarm starts,
//     press ignored.
// - alarm_req high at reset release does not start an alarm. A rising edge is required.
// - Mid-operation reset: outputs drop to 0 immediately (async).
// CONFIGURATION
//   ALARM_BEEPER_SNOOZE_EN defined:
//   - A press while ringing -> SNOOZE (buzzer_on=0, no_buzz=1).
//   - After SNOOZE_MS -> BEEP_ON with beep_idx=0 and burst_cnt=0.
//   - A press in SNOOZE -> SILENCED. alarm_req low in SNOOZE -> IDLE.
//   Undefined: no SNOOZE state and SNOOZE_MS unused. A press while ringing -> SILENCED.
// TESTING (CLK_HZ=10_000, TICK_HZ=1000 -> tick every 10 cycles; ON_MS=2, OFF_MS=1,
//          BEEPS=2, PAUSE_MS=3, MAX_BURSTS=2, DEBOUNCE_MS=2, SNOOZE_MS=5)
// 1 Reset, alarm_req low -> buzzer_on=no_buzz=alarm_active=0, burst_cnt=0.
// 2 alarm_req rise, held -> buzzer_on pattern 20 hi/10 lo/20 hi/30 lo, repeated twice.
//   Then DONE: buzzer_on=0, no_buzz=1, burst_cnt=2. Drop alarm_req -> all 0.
// 3 Press held 40 cycles mid-BEEP_ON -> buzzer_on=0, no_buzz=1 within 35 cycles.
//   A 5-cycle glitch on silence_btn -> no effect.
// 4 alarm_req drop mid-BEEP_OFF, same cycle as accepted press -> IDLE next cycle,
//   no_buzz stays 0.
// 5 rst_n low for 3 cycles mid-BEEP_ON -> buzzer_on=0 immediately.
//   alarm_req still high after release -> stays IDLE.
// 6 SNOOZE_EN: press while ringing -> 50 cycles silent with no_buzz=1, then buzzer_on
//   rises with burst_cnt=0. Second press during snooze -> SILENCED.

Source files
------------

// File: rtl/alarm_beeper.sv
// Alarm cadence generator: a level alarm request becomes bursts of short beeps on buzzer_on, and a debounced silence button mutes it through no_buzz.
// Optional snooze (define ALARM_BEEPER_SNOOZE_EN): a press while ringing pauses for SNOOZE_MS ticks, then the alarm starts over.
module alarm_beeper #(
  parameter int unsigned CLK_HZ      = 100_000_000,
  parameter int unsigned TICK_HZ     = 1000,
  parameter int unsigned ON_MS       = 200,
  parameter int unsigned OFF_MS      = 100,
  parameter int unsigned BEEPS       = 3,
  parameter int unsigned PAUSE_MS    = 1000,
  parameter int unsigned MAX_BURSTS  = 30,
  parameter int unsigned DEBOUNCE_MS = 20,
  parameter int unsigned SNOOZE_MS   = 60000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       alarm_req,
  input  logic       silence_btn,
  output logic       buzzer_on,
  output logic       no_buzz,
  output logic       alarm_active,
  output logic [7:0] burst_cnt,
  output logic [2:0] state_dbg
);

  localparam int unsigned DIV = (CLK_HZ / TICK_HZ > 1) ? CLK_HZ / TICK_HZ : 1;
  localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned M1  = (ON_MS > OFF_MS) ? ON_MS : OFF_MS;
  localparam int unsigned M2  = (M1 > PAUSE_MS) ? M1 : PAUSE_MS;
  localparam int unsigned M3  = (M2 > SNOOZE_MS) ? M2 : SNOOZE_MS;
  localparam int unsigned TW  = $clog2(M3 + 1);
  localparam int unsigned DW  = $clog2(DEBOUNCE_MS + 1);
  localparam int unsigned BW  = $clog2(BEEPS + 1);

  localparam logic [PW-1:0] PRESC_END = PW'(DIV - 1);
  localparam logic [TW-1:0] ON_END    = TW'(ON_MS - 1);
  localparam logic [TW-1:0] OFF_END   = TW'(OFF_MS - 1);
  localparam logic [TW-1:0] PAUSE_END = TW'(PAUSE_MS - 1);
  localparam logic [DW-1:0] DB_END    = DW'(DEBOUNCE_MS - 1);
  localparam logic [BW-1:0] LAST_BEEP = BW'(BEEPS - 1);
`ifdef ALARM_BEEPER_SNOOZE_EN
  localparam logic [TW-1:0] SNOOZE_END = TW'(SNOOZE_MS - 1);
`endif

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    BEEP_ON  = 3'd1,
    BEEP_OFF = 3'd2,
    PAUSE    = 3'd3,
    SILENCED = 3'd4,
    DONE     = 3'd5
`ifdef ALARM_BEEPER_SNOOZE_EN
    , SNOOZE = 3'd6
`endif
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q;
  logic [TW-1:0] timer_q, dur_end;
  logic [BW-1:0] beep_idx_q, beep_idx_d;
  logic [7:0]    burst_d;
  logic [31:0]   bursts_done;
  logic [1:0]    sync_q;
  logic [DW-1:0] db_cnt;
  logic          db_level, db_prev, req_d;
  logic          tick, req_rise, press, phase_end, start, mute_d;

  assign tick        = (presc_q == PRESC_END);
  assign req_rise    = alarm_req & ~req_d;
  assign press       = db_level & ~db_prev;
  assign start       = (state_q == IDLE) && req_rise;
  assign phase_end   = tick && (timer_q == dur_end);
  assign bursts_done = {24'd0, burst_cnt} + 32'd1;
  assign state_dbg   = state_q;

  // req_d resets high so a request already asserted at reset release is not an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_d    <= 1'b1;
      sync_q   <= '0;
      db_level <= 1'b0;
      db_prev  <= 1'b0;
      db_cnt   <= '0;
      presc_q  <= '0;
    end else begin
      req_d   <= alarm_req;
      sync_q  <= {sync_q[0], silence_btn};
      db_prev <= db_level;
      if (sync_q[1] == db_level) begin
        db_cnt <= '0;
      end else if (tick) begin
        if (db_cnt == DB_END) begin
          db_level <= sync_q[1];
          db_cnt   <= '0;
        end else begin
          db_cnt <= db_cnt + DW'(1);
        end
      end
      if (start || tick) presc_q <= '0;
      else               presc_q <= presc_q + PW'(1);
    end
  end

  always_comb begin
    dur_end = '0;
    case (state_q)
      BEEP_ON:  dur_end = ON_END;
      BEEP_OFF: dur_end = OFF_END;
      PAUSE:    dur_end = PAUSE_END;
`ifdef ALARM_BEEPER_SNOOZE_EN
      SNOOZE:   dur_end = SNOOZE_END;
`endif
      default:  dur_end = '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    beep_idx_d = beep_idx_q;
    burst_d    = burst_cnt;
    case (state_q)
      IDLE: if (req_rise) begin
        state_d    = BEEP_ON;
        beep_idx_d = '0;
        burst_d    = '0;
      end
      BEEP_ON, BEEP_OFF, PAUSE: begin
        if (!alarm_req) begin
          state_d = IDLE;
        end else if (press) begin
`ifdef ALARM_BEEPER_SNOOZE_EN
          state_d = SNOOZE;
`else
          state_d = SILENCED;
`endif
        end else if (phase_end) begin
          case (state_q)
            BEEP_ON: state_d = (beep_idx_q == LAST_BEEP) ? PAUSE : BEEP_OFF;
            BEEP_OFF: begin
              state_d    = BEEP_ON;
              beep_idx_d = beep_idx_q + BW'(1);
            end
            default: begin
              burst_d    = (burst_cnt == 8'hFF) ? burst_cnt : burst_cnt + 8'd1;
              beep_idx_d = '0;
              state_d    = (MAX_BURSTS != 0 && bursts_done >= MAX_BURSTS) ? DONE : BEEP_ON;
            end
          endcase
        end
      end
      SILENCED, DONE: if (!alarm_req) state_d = IDLE;
`ifdef ALARM_BEEPER_SNOOZE_EN
      SNOOZE: begin
        if (!alarm_req) begin
          state_d = IDLE;
        end else if (press) begin
          state_d = SILENCED;
        end else if (phase_end) begin
          state_d    = BEEP_ON;
          beep_idx_d = '0;
          burst_d    = '0;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
    if (state_d == IDLE) begin
      beep_idx_d = '0;
      burst_d    = '0;
    end
  end

  always_comb begin
    mute_d = (state_d == SILENCED) || (state_d == DONE);
`ifdef ALARM_BEEPER_SNOOZE_EN
    if (state_d == SNOOZE) mute_d = 1'b1;
`endif
  end

  // Outputs are registered from the next state so they change on the same edge as the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      beep_idx_q   <= '0;
      burst_cnt    <= '0;
      buzzer_on    <= 1'b0;
      no_buzz      <= 1'b0;
      alarm_active <= 1'b0;
    end else begin
      state_q      <= state_d;
      beep_idx_q   <= beep_idx_d;
      burst_cnt    <= burst_d;
      buzzer_on    <= (state_d == BEEP_ON);
      no_buzz      <= mute_d;
      alarm_active <= (state_d != IDLE);
      if (state_d != state_q) timer_q <= '0;
      else if (tick)          timer_q <= timer_q + TW'(1);
    end
  end

endmodule

// File: tb/tb_alarm_beeper.sv
// Directed bench for alarm_beeper with a 10-cycle tick; sample index k means "just after the k-th edge after the alarm start edge".
// Define ALARM_BEEPER_SNOOZE_EN for both files to include the snooze scenarios.
module tb_alarm_beeper;
  logic       clk = 1'b0;
  logic       rst_n, alarm_req, silence_btn;
  logic       buzzer_on, no_buzz, alarm_active;
  logic [7:0] burst_cnt;
  logic [2:0] state_dbg;
  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  alarm_beeper #(
    .CLK_HZ(10_000), .TICK_HZ(1000), .ON_MS(2), .OFF_MS(1), .BEEPS(2),
    .PAUSE_MS(3), .MAX_BURSTS(2), .DEBOUNCE_MS(2), .SNOOZE_MS(5)
  ) dut (
    .clk(clk), .rst_n(rst_n), .alarm_req(alarm_req), .silence_btn(silence_btn),
    .buzzer_on(buzzer_on), .no_buzz(no_buzz), .alarm_active(alarm_active),
    .burst_cnt(burst_cnt), .state_dbg(state_dbg)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench at sample 0 (just after the edge that starts the alarm).
  task automatic start_alarm();
    alarm_req = 1'b0;
    repeat (3) step();
    alarm_req = 1'b1;
    step();
  endtask

  task automatic end_alarm();
    alarm_req   = 1'b0;
    silence_btn = 1'b0;
    repeat (40) step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; alarm_req = 1'b0; silence_btn = 1'b0;
    repeat (4) step();
    n_total++;
    if ({buzzer_on, no_buzz, alarm_active} !== 3'b000 || burst_cnt !== 8'd0)
      $display("FAIL reset_in: got %b/%0d expected 000/0", {buzzer_on, no_buzz, alarm_active}, burst_cnt);
    else n_pass++;
    rst_n = 1'b1;
    repeat (5) step();
    n_total++;
    if ({buzzer_on, no_buzz, alarm_active} !== 3'b000 || burst_cnt !== 8'd0)
      $display("FAIL reset_out: got %b/%0d expected 000/0", {buzzer_on, no_buzz, alarm_active}, burst_cnt);
    else n_pass++;
  endtask

  task automatic test_burst_pattern();
    int bad = 0;
    int first_bad = -1;
    logic exp_b;
    int pos;
    start_alarm();
    for (int i = 0; i < 160; i++) begin
      pos   = i % 80;
      exp_b = (pos < 20) || (pos >= 30 && pos < 50);
      if (buzzer_on !== exp_b || burst_cnt !== 8'(i / 80) || no_buzz !== 1'b0 || alarm_active !== 1'b1) begin
        bad++;
        if (first_bad < 0) first_bad = i;
      end
      step();
    end
    n_total++;
    if (bad !== 0) $display("FAIL pattern: %0d bad cycles (first at %0d) expected 0", bad, first_bad);
    else n_pass++;
    n_total++;
    if ({buzzer_on, no_buzz, alarm_active} !== 3'b011)
      $display("FAIL done_outs: got %b expected 011", {buzzer_on, no_buzz, alarm_active});
    else n_pass++;
    n_total++;
    if (burst_cnt !== 8'd2) $display("FAIL done_bursts: got %0d expected 2", burst_cnt);
    else n_pass++;
    repeat (30) step();
    n_total++;
    if ({buzzer_on, no_buzz} !== 2'b01) $display("FAIL done_hold: got %b expected 01", {buzzer_on, no_buzz});
    else n_pass++;
    alarm_req = 1'b0;
    step();
    n_total++;
    if ({buzzer_on, no_buzz, alarm_active} !== 3'b000 || burst_cnt !== 8'd0)
      $display("FAIL done_drop: got %b/%0d expected 000/0", {buzzer_on, no_buzz, alarm_active}, burst_cnt);
    else n_pass++;
    end_alarm();
  endtask

  task automatic test_idle_press();
    silence_btn = 1'b1;
    repeat (40) step();
    n_total++;
    if ({no_buzz, alarm_active} !== 2'b00) $display("FAIL idle_press: got %b expected 00", {no_buzz, alarm_active});
    else n_pass++;
    start_alarm();
    repeat (10) step();
    n_total++;
    if ({buzzer_on, no_buzz} !== 2'b10) $display("FAIL held_btn_ring: got %b expected 10", {buzzer_on, no_buzz});
    else n_pass++;
    end_alarm();
  endtask

  task automatic test_silence();
    int lat = -1;
    start_alarm();
    repeat (2) step();
    silence_btn = 1'b1;
    repeat (5) step();
    silence_btn = 1'b0;
    repeat (28) step();
    n_total++;
    if ({buzzer_on, no_buzz} !== 2'b10) $display("FAIL glitch: got %b expected 10", {buzzer_on, no_buzz});
    else n_pass++;
    silence_btn = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (lat < 0 && no_buzz === 1'b1 && buzzer_on === 1'b0) lat = k;
    end
    silence_btn = 1'b0;
    n_total++;
    if (lat < 12 || lat > 35) $display("FAIL silence_latency: got %0d expected 12..35", lat);
    else n_pass++;
    repeat (60) step();
    n_total++;
    if ({buzzer_on, no_buzz, alarm_active} !== 3'b011)
      $display("FAIL silenced_hold: got %b expected 011", {buzzer_on, no_buzz, alarm_active});
    else n_pass++;
    alarm_req = 1'b0;
    step();
    n_total++;
    if ({buzzer_on, no_buzz, alarm_active} !== 3'b000)
      $display("FAIL silenced_drop: got %b expected 000", {buzzer_on, no_buzz, alarm_active});
    else n_pass++;
    end_alarm();
  endtask

  // Press accepted at edge 21 while in BEEP_OFF; the request drops on that same edge.
  task automatic test_drop_vs_press();
    int bad = 0;
    start_alarm();
    repeat (5) step();
    silence_btn = 1'b1;
    repeat (15) step();
    n_total++;
    if ({buzzer_on, no_buzz, alarm_active} !== 3'b001)
      $display("FAIL in_beep_off: got %b expected 001", {buzzer_on, no_buzz, alarm_active});
    else n_pass++;
    alarm_req = 1'b0;
    step();
    n_total++;
    if ({buzzer_on, no_buzz, alarm_active} !== 3'b000)
      $display("FAIL drop_priority: got %b expected 000", {buzzer_on, no_buzz, alarm_active});
    else n_pass++;
    for (int k = 0; k < 20; k++) begin
      step();
      if (no_buzz !== 1'b0 || alarm_active !== 1'b0) bad++;
    end
    n_total++;
    if (bad !== 0) $display("FAIL drop_stays_idle: %0d bad cycles expected 0", bad);
    else n_pass++;
    end_alarm();
  endtask

  task automatic test_mid_reset();
    start_alarm();
    repeat (5) step();
    n_total++;
    if (buzzer_on !== 1'b1) $display("FAIL pre_reset_beep: got %b expected 1", buzzer_on);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({buzzer_on, alarm_active} !== 2'b00) $display("FAIL async_reset: got %b expected 00", {buzzer_on, alarm_active});
    else n_pass++;
    repeat (3) step();
    rst_n = 1'b1;
    repeat (30) step();
    n_total++;
    if ({buzzer_on, no_buzz, alarm_active} !== 3'b000)
      $display("FAIL req_high_at_release: got %b expected 000", {buzzer_on, no_buzz, alarm_active});
    else n_pass++;
    start_alarm();
    n_total++;
    if ({buzzer_on, alarm_active} !== 2'b11) $display("FAIL restart_after_reset: got %b expected 11", {buzzer_on, alarm_active});
    else n_pass++;
    end_alarm();
  endtask

`ifdef ALARM_BEEPER_SNOOZE_EN
  task automatic test_snooze();
    int bad = 0;
    start_alarm();
    repeat (85) step();
    silence_btn = 1'b1;
    repeat (16) step();
    silence_btn = 1'b0;
    for (int k = 101; k < 150; k++) begin
      if ({buzzer_on, no_buzz, alarm_active} !== 3'b011) bad++;
      step();
    end
    n_total++;
    if (bad !== 0) $display("FAIL snooze_silent: %0d bad cycles expected 0", bad);
    else n_pass++;
    n_total++;
    if ({buzzer_on, no_buzz} !== 2'b10 || burst_cnt !== 8'd0)
      $display("FAIL snooze_expiry: got %b/%0d expected 10/0", {buzzer_on, no_buzz}, burst_cnt);
    else n_pass++;
    end_alarm();
    bad = 0;
    start_alarm();
    repeat (5) step();
    silence_btn = 1'b1;
    repeat (16) step();
    n_total++;
    if ({buzzer_on, no_buzz} !== 2'b01) $display("FAIL snooze_enter: got %b expected 01", {buzzer_on, no_buzz});
    else n_pass++;
    silence_btn = 1'b0;
    repeat (20) step();
    silence_btn = 1'b1;
    repeat (20) step();
    for (int k = 61; k < 100; k++) begin
      if ({buzzer_on, no_buzz, alarm_active} !== 3'b011) bad++;
      step();
    end
    n_total++;
    if (bad !== 0) $display("FAIL snooze_to_silenced: %0d bad cycles expected 0", bad);
    else n_pass++;
    end_alarm();
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_burst_pattern();
    test_idle_press();
    test_silence();
    test_drop_vs_press();
    test_mid_reset();
`ifdef ALARM_BEEPER_SNOOZE_EN
    test_snooze();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
